// File: rtl/music_ctrl_pkg.sv
// Shared definitions for the music player: play-state encoding used by
// music_ctrl and the top-level player.
package music_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_STOP  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10
  } play_state_e;

  // Map any encoding outside the legal set back to STOP.
  function automatic play_state_e sanitize_state(input play_state_e s);
    case (s)
      ST_STOP, ST_PLAY, ST_PAUSE: sanitize_state = s;
      default:                    sanitize_state = ST_STOP;
    endcase
  endfunction

endpackage

// File: rtl/music_idx_ctr.sv
// Track index counter: wraps between 0 and NUM_SONGS-1 in both directions,
// with a synchronous clear and an asynchronous active-high reset.
module music_idx_ctr #(
  parameter int NUM_SONGS = 4,
  parameter int IDX_W     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  output logic [IDX_W-1:0] idx,
  output logic             at_last
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SONGS - 1);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // Wrap against the real track count, not the full index range.
  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
    end else if (dec) begin
      idx_d = (idx_q == '0) ? LAST : idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx     = idx_q;
  assign at_last = (idx_q == LAST);

endmodule

// File: rtl/music_ctrl.sv
// Music player controller: STOP/PLAY/PAUSE state machine driven by button
// pulses and the sequencer's end-of-track strobe, with registered outputs.
module music_ctrl
  import music_ctrl_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int IDX_W     = 2,
  parameter int LOOP      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             play_pulse,
  input  logic             next_pulse,
  input  logic             prev_pulse,
  input  logic             song_done,
  output logic             playing,
  output logic [IDX_W-1:0] song,
  output logic             new_song
);

  play_state_e state_q;
  play_state_e state_d;
  logic        playing_q;
  logic        playing_d;
  logic        new_song_q;
  logic        new_song_d;

  logic        idx_inc;
  logic        idx_dec;
  logic        idx_clear;
  logic        idx_at_last;

  // One event per cycle, highest priority first; the rest are dropped.
  always_comb begin
    state_d    = sanitize_state(state_q);
    new_song_d = 1'b0;
    idx_inc    = 1'b0;
    idx_dec    = 1'b0;
    idx_clear  = 1'b0;

    if (play_pulse) begin
      case (state_q)
        ST_STOP: begin
          state_d    = ST_PLAY;
          new_song_d = 1'b1;
        end
        ST_PLAY:  state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_PLAY;
        default:  state_d = ST_STOP;
      endcase
    end else if (next_pulse) begin
      idx_inc    = 1'b1;
      new_song_d = 1'b1;
    end else if (prev_pulse) begin
      idx_dec    = 1'b1;
      new_song_d = 1'b1;
    end else if (song_done && (state_q == ST_PLAY)) begin
      if (!idx_at_last || (LOOP != 0)) begin
        idx_inc    = 1'b1;
        new_song_d = 1'b1;
      end else begin
        idx_clear = 1'b1;
        state_d   = ST_STOP;
      end
    end

    playing_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_STOP;
      playing_q  <= 1'b0;
      new_song_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      playing_q  <= playing_d;
      new_song_q <= new_song_d;
    end
  end

  music_idx_ctr #(
    .NUM_SONGS (NUM_SONGS),
    .IDX_W     (IDX_W)
  ) u_idx_ctr (
    .clk     (clk),
    .reset   (reset),
    .inc     (idx_inc),
    .dec     (idx_dec),
    .clear   (idx_clear),
    .idx     (song),
    .at_last (idx_at_last)
  );

  assign playing  = playing_q;
  assign new_song = new_song_q;

endmodule
